// File: rtl/mce_pkg.sv
// -----------------------------------------------------------------------------
// mce_pkg
// Shared definitions for the memory copy engine.
//   - default widths of the 2048x8 multi-bank memory port
//   - FSM state encodings
//   - leaf-index extraction used by the read/write conflict check
// -----------------------------------------------------------------------------
package mce_pkg;

    localparam int MCE_ADDR_W = 11;  // memory byte address width
    localparam int MCE_DATA_W = 8;   // memory data width
    localparam int MCE_LEN_W  = 12;  // copy length width, holds 0..2048
    localparam int MCE_LEAF_W = 4;   // upper address bits selecting a 128-entry leaf

    typedef logic [1:0] mce_state_t;

    localparam mce_state_t ST_IDLE  = 2'd0;
    localparam mce_state_t ST_RUN   = 2'd1;
    localparam mce_state_t ST_DRAIN = 2'd2;
    localparam mce_state_t ST_DONE  = 2'd3;

    // Leaf index of an address: its top leaf_w bits, right-aligned.
    function automatic logic [MCE_ADDR_W-1:0] leaf_idx(input logic [MCE_ADDR_W-1:0] addr,
                                                       input int                    leaf_w);
        return addr >> (MCE_ADDR_W - leaf_w);
    endfunction

endpackage

// File: rtl/mce_conflict_chk.sv
// -----------------------------------------------------------------------------
// mce_conflict_chk
// Combinational leaf-collision detector. A read must be held back when the
// write going out in the same cycle targets the same leaf array, because the
// memory returns 0 for such a read.
//
// Ports:
//   rd_addr_i     in   ADDR_W  address of the read about to be issued
//   wr_addr_i     in   ADDR_W  address of the write about to be issued
//   wr_en_i       in   1       a write is about to be issued
//   read_stall_o  out  1       hold the read this cycle
// -----------------------------------------------------------------------------
module mce_conflict_chk
    import mce_pkg::*;
#(
    parameter int ADDR_W = MCE_ADDR_W,
    parameter int LEAF_W = MCE_LEAF_W
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              wr_en_i,
    output logic              read_stall_o
);

    assign read_stall_o = wr_en_i &&
                          (leaf_idx(rd_addr_i, LEAF_W) == leaf_idx(wr_addr_i, LEAF_W));

endmodule

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Copies len bytes from src_addr to dst_addr inside one 2048x8 memory with a
// 1-cycle registered read. Ascending order, up to one byte per cycle. Each byte
// goes read (cycle n) -> capture mem_dout (n+1) -> write (n+2). Only reads
// are ever held back, so at most two bytes are in flight.
//
// Optional build macro: MCE_CHECKSUM_EN adds the checksum output (XOR of all
// bytes written in the current copy).
//
// Ports:
//   clk       in   1       clock, rising edge
//   rst_n     in   1       synchronous active-low reset
//   start     in   1       copy request, honoured only in IDLE
//   src_addr  in   ADDR_W  source base, latched on start
//   dst_addr  in   ADDR_W  destination base, latched on start
//   len       in   LEN_W   byte count (0..2048), latched on start
//   busy      out  1       copy in progress
//   done      out  1       one-cycle completion pulse
//   ren       out  1       memory read enable
//   raddr     out  ADDR_W  memory read address
//   wen       out  1       memory write enable
//   waddr     out  ADDR_W  memory write address
//   din       out  DATA_W  memory write data
//   mem_dout  in   DATA_W  memory read data, valid the cycle after ren
//   checksum  out  DATA_W  (MCE_CHECKSUM_EN only) XOR of bytes written
// -----------------------------------------------------------------------------
module mem_copy_engine
    import mce_pkg::*;
#(
    parameter int ADDR_W = MCE_ADDR_W,
    parameter int DATA_W = MCE_DATA_W,
    parameter int LEN_W  = MCE_LEN_W,
    parameter int LEAF_W = MCE_LEAF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef MCE_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    mce_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              rd_vld_p1_q;   // a read went out last cycle, so mem_dout holds its byte
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic              wr_fire;
    logic              read_stall;

    // Address sums wrap modulo 2^ADDR_W by truncation.
    assign wr_fire     = rd_vld_p1_q;
    assign rd_addr_nxt = src_q + rd_cnt_q[ADDR_W-1:0];
    assign wr_addr_nxt = dst_q + wr_cnt_q[ADDR_W-1:0];

    mce_conflict_chk #(
        .ADDR_W (ADDR_W),
        .LEAF_W (LEAF_W)
    ) u_conflict_chk (
        .rd_addr_i    (rd_addr_nxt),
        .wr_addr_i    (wr_addr_nxt),
        .wr_en_i      (wr_fire),
        .read_stall_o (read_stall)
    );

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ren_d    = 1'b0;
        raddr_d  = raddr_q;

        // Write stage runs independently of the FSM: every captured byte is
        // written the cycle after it arrives, and writes are never held.
        wen_d   = wr_fire;
        waddr_d = waddr_q;
        din_d   = din_q;
        if (wr_fire) begin
            waddr_d  = wr_addr_nxt;
            din_d    = mem_dout;
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // First read goes out on the accept edge; the pipeline
                        // is empty here, so no conflict check is needed.
                        src_d    = src_addr;
                        dst_d    = dst_addr;
                        len_d    = len;
                        rd_cnt_d = {{(LEN_W-1){1'b0}}, 1'b1};
                        wr_cnt_d = '0;
                        busy_d   = 1'b1;
                        ren_d    = 1'b1;
                        raddr_d  = src_addr;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if ((rd_cnt_q != len_q) && !read_stall) begin
                    ren_d    = 1'b1;
                    raddr_d  = rd_addr_nxt;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (rd_cnt_d == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // wr_cnt reaching len means the last write is on the port now.
                if (wr_cnt_q == len_q) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            rd_vld_p1_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_vld_p1_q <= ren_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            din_q       <= din_d;
        end
    end

`ifdef MCE_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && start) begin
            csum_d = '0;
        end else if (wr_fire) begin
            csum_d = csum_q ^ mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign ren   = ren_q;
    assign raddr = raddr_q;
    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign din   = din_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Directed bench for mem_copy_engine with a behavioural 2048x8 memory
// (registered read, reads colliding with a same-leaf write return 0).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] src_addr;
    logic [10:0] dst_addr;
    logic [11:0] len;
    logic        busy;
    logic        done;
    logic        ren;
    logic [10:0] raddr;
    logic        wen;
    logic [10:0] waddr;
    logic [7:0]  din;
    logic [7:0]  mem_dout;
`ifdef MCE_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .ren      (ren),
        .raddr    (raddr),
        .wen      (wen),
        .waddr    (waddr),
        .din      (din),
        .mem_dout (mem_dout)
`ifdef MCE_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // Memory model plus a bench-side preload port.
    logic [7:0]  mem [2048];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (ren) mem_dout <= (wen && (raddr[10:7] == waddr[10:7])) ? 8'h00 : mem[raddr];
        if (wen) mem[waddr] <= din;
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    // Cumulative activity monitor, sampled on the falling edge.
    int unsigned cyc = 0;
    int unsigned ren_cnt = 0, wen_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int unsigned stall_cnt = 0, clash_cnt = 0;
    int unsigned last_ren_cyc = 0, last_done_cyc = 0;
    int unsigned copy_len = 0, ren_base = 0;
    logic [10:0] raddr_log [4096];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (ren) begin
                raddr_log[ren_cnt[11:0]] <= raddr;
                ren_cnt      <= ren_cnt + 1;
                last_ren_cyc <= cyc + 1;
            end
            if (wen) wen_cnt <= wen_cnt + 1;
            if (done) begin
                done_cnt      <= done_cnt + 1;
                last_done_cyc <= cyc + 1;
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            if (busy && !ren && ((ren_cnt - ren_base) < copy_len)) stall_cnt <= stall_cnt + 1;
            if (ren && wen && (raddr[10:7] == waddr[10:7])) clash_cnt <= clash_cnt + 1;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int unsigned t0 = 0;
    int unsigned wen_base = 0, done_base = 0, busy_base = 0, stall_base = 0;

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present a start for one cycle; returns at the falling edge of cycle 1.
    task automatic launch(input logic [10:0] s, input logic [10:0] d, input logic [11:0] n);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk);
        t0 = cyc; ren_base = ren_cnt; wen_base = wen_cnt; done_base = done_cnt;
        busy_base = busy_cnt; stall_base = stall_cnt; copy_len = 32'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Latency is the cycle (start cycle = 0) in which done is seen; -1 on timeout.
    task automatic wait_done(input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        @(posedge clk);
    endtask

    logic [5:0] rmap, wmap, dmap, bmap;
    logic [3:0] or_ctl;
    logic [10:0] or_addr;
    logic [7:0]  or_din;
    int          lat;
    int          k;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held 3 cycles with start asserted.
        rst_n = 1'b0; start = 1'b1; src_addr = 11'd5; dst_addr = 11'd9; len = 12'd4;
        or_ctl = '0; or_addr = '0; or_din = '0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            or_ctl  = or_ctl | {busy, done, ren, wen};
            or_addr = or_addr | raddr | waddr;
            or_din  = or_din | din;
        end
        check_val("rst_busy", 32'(or_ctl[3]), 0);
        check_val("rst_done", 32'(or_ctl[2]), 0);
        check_val("rst_ren", 32'(or_ctl[1]), 0);
        check_val("rst_wen", 32'(or_ctl[0]), 0);
        check_val("rst_addr", 32'(or_addr), 0);
        check_val("rst_din", 32'(or_din), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_busy", 32'(busy), 0);

        // len=1 cycle-exact timing: ren@1, wen@3, done@4, busy@1..3.
        poke(11'd200, 8'h5C);
        launch(11'd200, 11'd1500, 12'd1);
        rmap = '0; wmap = '0; dmap = '0; bmap = '0;
        for (int i = 1; i <= 5; i++) begin
            rmap[i] = ren; wmap[i] = wen; dmap[i] = done; bmap[i] = busy;
            @(negedge clk);
        end
        @(posedge clk);
        check_val("len1_ren_map", 32'(rmap), 32'h02);
        check_val("len1_wen_map", 32'(wmap), 32'h08);
        check_val("len1_done_map", 32'(dmap), 32'h10);
        check_val("len1_busy_map", 32'(bmap), 32'h0E);
        check_val("len1_data", 32'(mem[1500]), 32'h5C);

        // Simple copy, no leaf conflicts.
        poke(11'd0, 8'h11); poke(11'd1, 8'h22); poke(11'd2, 8'h33); poke(11'd3, 8'h44);
        launch(11'd0, 11'd1024, 12'd4);
        wait_done(50, lat);
        check_val("simple_latency", 32'(lat), 7);
        check_val("simple_ren_to_done", last_done_cyc - last_ren_cyc, 3);
        check_val("simple_stalls", stall_cnt - stall_base, 0);
        check_val("simple_d0", 32'(mem[1024]), 32'h11);
        check_val("simple_d1", 32'(mem[1025]), 32'h22);
        check_val("simple_d2", 32'(mem[1026]), 32'h33);
        check_val("simple_d3", 32'(mem[1027]), 32'h44);
`ifdef MCE_CHECKSUM_EN
        check_val("simple_checksum", 32'(checksum), 32'h44);
`endif

        // Same-leaf conflict: reads pause while writes to leaf 0 go out.
        for (int i = 0; i < 8; i++) poke(11'(i), 8'(8'hA0 + i));
        launch(11'd0, 11'd64, 12'd8);
        wait_done(60, lat);
        check_val("conf_latency", 32'(lat), 17);
        check_val("conf_stalls", stall_cnt - stall_base, 6);
        check_val("conf_ren", ren_cnt - ren_base, 8);
        check_val("conf_leaf_clash", clash_cnt, 0);
        for (int i = 0; i < 8; i++) check_val("conf_data", 32'(mem[64 + i]), 32'(8'hA0 + i));

        // Wrap-around at the top of the address space.
        poke(11'd2046, 8'hA1); poke(11'd2047, 8'hB2); poke(11'd0, 8'hC3); poke(11'd1, 8'hD4);
        launch(11'd2046, 11'd512, 12'd4);
        wait_done(50, lat);
        check_val("wrap_latency", 32'(lat), 7);
        check_val("wrap_raddr0", 32'(raddr_log[12'(ren_base + 0)]), 2046);
        check_val("wrap_raddr1", 32'(raddr_log[12'(ren_base + 1)]), 2047);
        check_val("wrap_raddr2", 32'(raddr_log[12'(ren_base + 2)]), 0);
        check_val("wrap_raddr3", 32'(raddr_log[12'(ren_base + 3)]), 1);
        check_val("wrap_d0", 32'(mem[512]), 32'hA1);
        check_val("wrap_d1", 32'(mem[513]), 32'hB2);
        check_val("wrap_d2", 32'(mem[514]), 32'hC3);
        check_val("wrap_d3", 32'(mem[515]), 32'hD4);

        // Zero length: done next cycle, no memory traffic, never busy.
        launch(11'd10, 11'd700, 12'd0);
        wait_done(10, lat);
        check_val("len0_latency", 32'(lat), 1);
        check_val("len0_ren", ren_cnt - ren_base, 0);
        check_val("len0_wen", wen_cnt - wen_base, 0);
        check_val("len0_busy", busy_cnt - busy_base, 0);

        // Full-memory copy with a stray start while busy.
        launch(11'd0, 11'd0, 12'd2048);
        repeat (100) @(negedge clk);
        src_addr = 11'd100; dst_addr = 11'd300; len = 12'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(12000, lat);
        repeat (10) @(negedge clk);
        @(posedge clk);
        check_val("big_finished", 32'(lat > 0), 1);
        check_val("big_wen", wen_cnt - wen_base, 2048);
        check_val("big_ren", ren_cnt - ren_base, 2048);
        check_val("big_done_pulses", done_cnt - done_base, 1);
        check_val("big_leaf_clash", clash_cnt, 0);

        // Abort with reset once the fifth read is on the port.
        for (int i = 0; i < 8; i++) poke(11'(i), 8'(8'h31 + i));
        poke(11'd1027, 8'hEE);
        launch(11'd0, 11'd1024, 12'd8);
        k = 0;
        for (int i = 0; i < 20 && k < 5; i++) begin
            if (ren) k++;
            if (k < 5) @(negedge clk);
        end
        check_val("abort_reads_seen", 32'(k), 5);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_done", 32'(done), 0);
        check_val("abort_ren", 32'(ren), 0);
        check_val("abort_wen", 32'(wen), 0);
        check_val("abort_raddr", 32'(raddr), 0);
        check_val("abort_waddr", 32'(waddr), 0);
        check_val("abort_din", 32'(din), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        done_base = done_cnt;
        repeat (10) @(negedge clk);
        @(posedge clk);
        check_val("abort_no_done", done_cnt - done_base, 0);
        check_val("abort_partial_w2", 32'(mem[1026]), 32'h33);
        check_val("abort_untouched_w3", 32'(mem[1027]), 32'hEE);

        // Fresh copy after the abort.
        poke(11'd16, 8'h5A); poke(11'd17, 8'h6B); poke(11'd18, 8'h7C);
        launch(11'd16, 11'd1100, 12'd3);
        wait_done(50, lat);
        check_val("post_latency", 32'(lat), 6);
        check_val("post_d0", 32'(mem[1100]), 32'h5A);
        check_val("post_d1", 32'(mem[1101]), 32'h6B);
        check_val("post_d2", 32'(mem[1102]), 32'h7C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
